// File: rtl/memory_port_arbiter_pkg.sv
// cpu_mem_pkg: shared state/owner types and default latency for the memory port arbiter
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} arb_owner_t;
  localparam int MEM_LATENCY_DEF = 2;
endpackage

// File: rtl/memory_port_arbiter_latency_counter.sv
// arb_latency_counter: loadable down-counter with zero flag timing the memory read latency
module arb_latency_counter #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  // load wins over decrement; the count saturates at zero
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between fetch and data paths; ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority
module memory_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  arb_state_t state;
  arb_owner_t own;
  logic lat_we, cnt_zero, grant_dm;
`ifdef ARB_ROUND_ROBIN_EN
  // the pointer is simply the last owner: on contention the side not served last wins
  assign grant_dm = dm_req && (!if_req || own == OWN_IF);
`else
  assign grant_dm = dm_req;
`endif
  assign owner  = own;
  assign busy   = state != IDLE;
  assign mem_en = state == ISSUE;
  assign mem_we = mem_en && lat_we;
  arb_latency_counter #(.W(CW)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (state == ISSUE),
    .dec      (state == WAIT),
    .load_val (CW'(MEM_LATENCY - 1)),
    .zero     (cnt_zero)
  );
  // transaction FSM: latch winner in IDLE, issue once, wait out latency, pulse done
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      own       <= OWN_IF;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: if (if_req || dm_req) begin
          state    <= ISSUE;
          own      <= grant_dm ? OWN_DM : OWN_IF;
          lat_we   <= grant_dm && dm_we;
          mem_addr <= grant_dm ? dm_addr : if_addr;
          if (grant_dm) mem_wdata <= dm_wdata;
        end
        ISSUE: state <= WAIT;
        WAIT: if (cnt_zero) begin
          state <= RESP;
          if (own == OWN_DM) begin
            dm_done <= 1'b1;
            if (!lat_we) dm_rdata <= mem_rdata;
          end else begin
            if_done  <= 1'b1;
            if_rdata <= mem_rdata[31:0];
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: randomized self-checking bench against a transaction-level model
module tb_memory_port_arbiter;
  import cpu_mem_pkg::*;
  localparam int L = MEM_LATENCY_DEF;
  logic        clock = 0, reset = 0;
  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [63:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic        if_done, dm_done, mem_en, mem_we, busy, owner;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata, mem_addr, mem_wdata;
  int checks = 0, errors = 0;
  logic [63:0] mem [16];
  bit          last_dm;
  logic [31:0] m_if;
  logic [63:0] m_dm;

  memory_port_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    if_req = 0;
    dm_req = 0;
    repeat (n) begin
      @(negedge clock);
      check("idle_busy", busy, 0);
      check("idle_if_done", if_done, 0);
      check("idle_dm_done", dm_done, 0);
    end
  endtask

  // one full transaction, entered and left at a negedge in IDLE
  task automatic txn(input bit ir, input bit dr, input bit we, input logic [63:0] ia,
                     input logic [63:0] da, input logic [63:0] wd, input bit glitch);
    bit win_dm, ewe;
    logic [63:0] a;
    int idx;
    if (!ir && !dr) return;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = we; dm_addr = da; dm_wdata = wd;
`ifdef ARB_ROUND_ROBIN_EN
    win_dm = dr && (!ir || !last_dm);
`else
    win_dm = dr;
`endif
    last_dm = win_dm;
    a = win_dm ? da : ia;
    ewe = win_dm && we;
    idx = int'(a[6:3]);
    for (int k = 0; k <= L + 2; k++) begin
      @(negedge clock);
      if (k == L + 1) begin
        if (ewe) mem[idx] = wd;
        else if (win_dm) m_dm = mem[idx];
        else m_if = mem[idx][31:0];
      end
      check("busy", busy, k <= L + 1);
      check("mem_en", mem_en, k == 0);
      check("mem_we", mem_we, k == 0 && ewe);
      check("mem_addr", mem_addr, a);
      if (win_dm) check("mem_wdata", mem_wdata, wd);
      check("owner", owner, win_dm);
      check("if_done", if_done, k == L + 1 && !win_dm);
      check("dm_done", dm_done, k == L + 1 && win_dm);
      check("if_rdata", if_rdata, m_if);
      check("dm_rdata", dm_rdata, m_dm);
      mem_rdata = (k == L) ? mem[idx] : {$urandom, $urandom};
      if (glitch && k >= 1 && k <= L) begin
        if_req = 0; if_addr = ia ^ 64'h30;
        dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
        dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
      end
      if (k == L + 1) begin if_req = 0; dm_req = 0; end
    end
  endtask

  function automatic logic [63:0] raddr();
    return {57'd0, 4'($urandom_range(0, 15)), 3'd0};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    mem[2] = {$urandom, 32'h0050_0093};
    last_dm = 0; m_if = 0; m_dm = 0;
    #1 reset = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_owner", owner, 0);
    @(negedge clock) reset = 0;
    txn(1, 0, 0, 64'h10, 0, 0, 0);
    check("fetch_word", if_rdata, 32'h0050_0093);
    txn(0, 1, 1, 0, 64'h80, 64'hDEAD_BEEF, 0);
    txn(1, 1, 0, 64'h18, 64'h88, 0, 0);
    txn(1, 0, 0, 64'h18, 0, 0, 0);
    idle(2);
    repeat (3) txn(1, 1, 0, raddr(), raddr(), 0, 0);
    txn(1, 0, 0, 64'h10, 0, 0, 1);
    if_req = 1; if_addr = 64'h28;
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_if_done", if_done, 0);
    check("mid_rst_dm_done", dm_done, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_if_rdata", if_rdata, 0);
    if_req = 0;
    @(negedge clock) reset = 0;
    last_dm = 0; m_if = 0; m_dm = 0;
    idle(L + 3);
    txn(0, 1, 0, 0, 64'h80, 0, 0);
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(1, 3);
      txn(r[0], r[1], 1'($urandom_range(0, 1)), raddr(), raddr(), {$urandom, $urandom},
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single 64-bit memory port of the multicycle CPU between the instruction-fetch path and the load/store data path. Each requester uses a hold-until-done handshake. The arbiter latches the winning request, drives one memory access, waits the fixed memory read latency, returns the data and pulses `done` to the winner. It sits between the CPU control unit / PC logic and the `Memoria64` instance.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: memory data width.
- `MEM_LATENCY`, default 2: number of cycles from the `mem_en` cycle until `mem_rdata` is valid. Must be ≥1.

Ports (reset `reset`, asynchronous, active-high; clock `clock`):
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high.
- `if_req`, in, 1: fetch request. Held until `if_done`.
- `if_addr`, in, ADDR_W: fetch address.
- `if_done`, out, 1: one-cycle completion pulse for fetch.
- `if_rdata`, out, 32: fetched instruction, equal to the captured `mem_rdata[31:0]`.
- `dm_req`, in, 1: data request. Held until `dm_done`.
- `dm_we`, in, 1: 1 = store, 0 = load.
- `dm_addr`, in, ADDR_W: data address.
- `dm_wdata`, in, DATA_W: store data.
- `dm_done`, out, 1: one-cycle completion pulse for data.
- `dm_rdata`, out, DATA_W: load data.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, ADDR_W: memory address.
- `mem_wdata`, out, DATA_W: memory write data.
- `mem_rdata`, in, DATA_W: memory read data.
- `busy`, out, 1: high in every state except IDLE.
- `owner`, out, 1: current or last grant. 0 = fetch, 1 = data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when `if_req` or `dm_req` is high at the clock edge.
  - The winner's addr/we/wdata are latched and `owner` is set.
  - A fetch always has `we` = 0.
- ISSUE:
  - Lasts exactly one cycle.
  - `mem_en` = 1, `mem_we` = latched we, `mem_addr`/`mem_wdata` = latched values.
  - Latency counter is loaded with MEM_LATENCY−1.
  - ISSUE → WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter is 0, `mem_rdata` is registered into the owner's rdata register (loads and fetches only; stores leave rdata unchanged). The FSM then moves WAIT → RESP.
- RESP:
  - Lasts one cycle.
  - The owner's `done` is high; the other requester's `done` stays low.
  - RESP → IDLE. New requests are sampled only in IDLE.
- Arbitration when both requests are high in IDLE is set by the configuration macro (see Configuration).
- Inputs are ignored outside IDLE, including address/data changes and a dropped `req`.
  - The latched transaction always completes and `done` still pulses.
- `mem_en` and `mem_we` are low in every state except ISSUE.
  - `mem_addr`/`mem_wdata` hold their latched values throughout.
- Outputs at reset:
  - FSM = IDLE, `mem_en` = `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0.
  - `if_done` = `dm_done` = 0, `busy` = 0, `owner` = 0.
  - Counter = 0, round-robin pointer = 0.

## Timing
- A request sampled at edge E0 gives:
  - ISSUE in cycle E0..E1.
  - `done` high during cycle E0+MEM_LATENCY+1 .. E0+MEM_LATENCY+2, with rdata valid in the same cycle.
- Total: `done` rises MEM_LATENCY+1 edges after the sampling edge, i.e. 3 edges with the default.
- Back-to-back transactions need one IDLE cycle between them, giving a throughput of one access per MEM_LATENCY+3 cycles.
- rdata outputs are registered and hold their value until the next completed read for that requester.
- Reset asserted mid-transaction:
  - All outputs take their reset values immediately (asynchronous).
  - No `done` is produced and the transaction is abandoned.
  - The requester must re-request after reset is released.
- Both requests high while the FSM is not in IDLE: no effect until IDLE.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, the grant goes to the requester not served last (pointer = last `owner`).
  - Pointer updates on each grant and starts at 0, so the first contention goes to data.
- `ARB_ROUND_ROBIN_EN` not defined:
  - Fixed priority: data always beats fetch.
  - No pointer register exists.

## Structure
- Package `cpu_mem_pkg` holds:
  - `typedef enum logic [1:0]` `arb_state_t` (IDLE, ISSUE, WAIT, RESP).
  - `typedef enum logic` `arb_owner_t` (OWN_IF = 0, OWN_DM = 1).
  - Constant `MEM_LATENCY_DEF` = 2.
- One sub-module, `arb_latency_counter`: a loadable down-counter with a `zero` flag, width $clog2(MEM_LATENCY)+1.

## Test plan
- Fetch only:
  - Stimulus: `if_addr` = 0x10; memory returns 0x00500093 two cycles after `mem_en`.
  - Required: `mem_en` pulses once with `mem_addr` = 0x10 and `mem_we` = 0; `if_done` pulses 3 edges after sampling; `if_rdata` = 0x00500093; `dm_done` stays 0.
- Store:
  - Stimulus: `dm_req`, `dm_we` = 1, `dm_addr` = 0x80, `dm_wdata` = 0xDEAD_BEEF.
  - Required: ISSUE cycle has `mem_we` = 1 with the same address/data; `dm_done` pulses; `dm_rdata` is unchanged.
- Contention without the macro:
  - Stimulus: `if_req` and `dm_req` rise together.
  - Required: data is served first; fetch is served second after one IDLE cycle.
- Contention with `ARB_ROUND_ROBIN_EN`:
  - Stimulus: three consecutive simultaneous-request rounds.
  - Required: grants follow the order DM, IF, DM.
- Mid-transaction reset:
  - Stimulus: assert reset during WAIT.
  - Required: `busy`, `mem_en` and both `done` outputs go to 0 immediately; no `done` pulse after release; next request completes normally.
- Input glitch:
  - Stimulus: change `if_addr` to 0x20 and drop `if_req` during WAIT.
  - Required: the transaction completes with `mem_addr` = 0x10 and `if_done` still pulses once.
